// File: rtl/input_buf_pkg.sv
// Shared types and default sizes for the
// input frame buffer controller.
package input_buf_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FULL = 2'd1,
    READ = 2'd2
  } buf_state_t;

  localparam int FRAME_DEPTH = 784;
  localparam int PIX_W       = 8;
  localparam int BRAM_ADDR_W = 16;

endpackage

// File: rtl/input_buffer_ctrl.sv
// Frame buffer sequencer: loads DEPTH pixels
// into external BRAM, then streams them out.
module input_buffer_ctrl
  import input_buf_pkg::*;
#(
  parameter int DEPTH  = FRAME_DEPTH,
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              start_read,
  output logic              frame_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE =
    ADDR_W'(1);

  buf_state_t        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;

  logic w_wr_last;
  logic w_rd_last;
  logic w_wr_fire;

  assign w_wr_last = (r_wr_ptr == LAST);
  assign w_rd_last = (r_rd_ptr == LAST);
  assign w_wr_fire = (r_state == LOAD)
                  && in_valid;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_state  <= LOAD;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      unique case (r_state)
        LOAD: begin
          if (w_wr_fire) begin
            if (w_wr_last) begin
              r_state  <= FULL;
              r_wr_ptr <= '0;
            end else begin
              r_wr_ptr <= r_wr_ptr + ONE;
            end
          end
        end
        FULL: begin
          if (start_read) begin
            r_state  <= READ;
            r_rd_ptr <= '0;
          end
        end
        READ: begin
          if (out_ready) begin
            if (w_rd_last) begin
              r_state  <= LOAD;
              r_rd_ptr <= '0;
            end else begin
              r_rd_ptr <= r_rd_ptr + ONE;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  // Read address runs one ahead on accept so
  // the registered BRAM output is never a bubble.
  always_comb begin
    in_ready    = 1'b0;
    frame_ready = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    bram_we     = 1'b0;
    bram_addr   = '0;
    bram_din    = '0;
    if (!rst) begin
      unique case (r_state)
        LOAD: begin
          in_ready  = 1'b1;
          bram_we   = in_valid && !abort;
          bram_addr = r_wr_ptr;
          if (in_valid && !abort)
            bram_din = in_data;
        end
        FULL: begin
          frame_ready = 1'b1;
        end
        READ: begin
          out_valid = 1'b1;
          out_last  = w_rd_last;
          bram_addr = out_ready
                    ? r_rd_ptr + ONE
                    : r_rd_ptr;
        end
        default: begin
          bram_addr = '0;
        end
      endcase
    end
  end

  assign out_data = bram_dout;

endmodule
